// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: drives the secret/guess register controls from
// START/ENTER, scores each guess by exact position matches, counts attempts and
// declares WIN or LOSE.
module mastermind_game_ctrl #(
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned TRY_W     = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ENTER,
  input  logic [3:0]       SECRET_Q,
  input  logic [3:0]       GUESS_Q,
  output logic             LOAD_SECRET,
  output logic             LOAD_GUESS,
  output logic             CLR_REGS,
  output logic [2:0]       HITS,
  output logic [TRY_W-1:0] TRIES,
  output logic             WIN,
  output logic             LOSE,
  output logic             BUSY
);

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StSetSecret,
    StLdSec,
    StWaitGuess,
    StLdGuess,
    StCompare,
    StWin,
    StLose
  } state_e;

  state_e             state_q, state_d;
  logic               enter_q;
  logic [2:0]         hits_q, hits_d;
  logic [TRY_W-1:0]   tries_q, tries_d;

  logic               enter_rise;
  logic [3:0]         match;
  logic [2:0]         match_cnt;
  logic [TRY_W-1:0]   tries_inc;
  logic               last_try;

  // One event per 0->1 edge; a level held high never re-triggers.
  assign enter_rise = ENTER & ~enter_q;

  assign match     = ~(SECRET_Q ^ GUESS_Q);
  assign tries_inc = tries_q + TRY_W'(1);
  assign last_try  = (tries_inc == TRY_W'(MAX_TRIES));

  // Count exact position matches between the two register outputs.
  always_comb begin
    match_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      match_cnt = match_cnt + {2'b00, match[i]};
    end
  end

  // State, score and enter-edge registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      enter_q <= 1'b1;  // ENTER held through reset must not look like a new press
      hits_q  <= 3'd0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= ENTER;
      hits_q  <= hits_d;
      tries_q <= tries_d;
    end
  end

  // Next-state, score update and Moore output decode.
  always_comb begin
    state_d     = state_q;
    hits_d      = hits_q;
    tries_d     = tries_q;
    LOAD_SECRET = 1'b0;
    LOAD_GUESS  = 1'b0;
    CLR_REGS    = 1'b0;
    WIN         = 1'b0;
    LOSE        = 1'b0;
    BUSY        = 1'b1;

    case (state_q)
      StIdle: begin
        BUSY = 1'b0;
        if (START) state_d = StClear;
      end
      StClear: begin
        CLR_REGS = 1'b1;
        hits_d   = 3'd0;
        tries_d  = '0;
        state_d  = StSetSecret;
      end
      StSetSecret: begin
        if (enter_rise) state_d = StLdSec;
      end
      StLdSec: begin
        LOAD_SECRET = 1'b1;
        state_d     = StWaitGuess;
      end
      StWaitGuess: begin
        if (enter_rise) state_d = StLdGuess;
      end
      StLdGuess: begin
        // Register captures at the end of this cycle; GUESS_Q is valid in compare.
        LOAD_GUESS = 1'b1;
        state_d    = StCompare;
      end
      StCompare: begin
        hits_d  = match_cnt;
        tries_d = tries_inc;
        // A full match wins even on the final try.
        if (match_cnt == 3'd4) begin
          state_d = StWin;
        end else if (last_try) begin
          state_d = StLose;
        end else begin
          state_d = StWaitGuess;
        end
      end
      StWin: begin
        WIN  = 1'b1;
        BUSY = 1'b0;
        if (START) state_d = StClear;
      end
      StLose: begin
        LOSE = 1'b1;
        BUSY = 1'b0;
        if (START) state_d = StClear;
      end
      default: begin
        BUSY    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign HITS  = hits_q;
  assign TRIES = tries_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl with a scoreboard of expected scores
// and a small model of the secret/guess register datapath.
module tb_mastermind_game_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       ENTER;
  logic [3:0] din;
  logic [3:0] sec_q, gs_q;

  // MAX_TRIES = 8 instance (main)
  logic       ls8, lg8, clr8, win8, lose8, busy8;
  logic [2:0] hits8;
  logic [3:0] tries8;
  // MAX_TRIES = 2 instance
  logic       ls2, lg2, clr2, win2, lose2, busy2;
  logic [2:0] hits2;
  logic [3:0] tries2;
  // MAX_TRIES = 1 instance
  logic       ls1, lg1, clr1, win1, lose1, busy1;
  logic [2:0] hits1;
  logic [3:0] tries1;

  int checks = 0;
  int errors = 0;
  int n_clr  = 0;
  int n_ls   = 0;
  int n_lg   = 0;
  int base_clr, base_ls, base_lg;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [2:0] hits;
    logic [3:0] tries;
    logic       win;
    logic       lose;
    logic       busy;
  } exp_t;
  exp_t sb[$];

  logic [12:0] all8;
  assign all8 = {ls8, lg8, clr8, win8, lose8, busy8, hits8, tries8};

  mastermind_game_ctrl #(.MAX_TRIES(8), .TRY_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ENTER(ENTER),
    .SECRET_Q(sec_q), .GUESS_Q(gs_q),
    .LOAD_SECRET(ls8), .LOAD_GUESS(lg8), .CLR_REGS(clr8),
    .HITS(hits8), .TRIES(tries8), .WIN(win8), .LOSE(lose8), .BUSY(busy8)
  );

  mastermind_game_ctrl #(.MAX_TRIES(2), .TRY_W(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .START(START), .ENTER(ENTER),
    .SECRET_Q(sec_q), .GUESS_Q(gs_q),
    .LOAD_SECRET(ls2), .LOAD_GUESS(lg2), .CLR_REGS(clr2),
    .HITS(hits2), .TRIES(tries2), .WIN(win2), .LOSE(lose2), .BUSY(busy2)
  );

  mastermind_game_ctrl #(.MAX_TRIES(1), .TRY_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START), .ENTER(ENTER),
    .SECRET_Q(sec_q), .GUESS_Q(gs_q),
    .LOAD_SECRET(ls1), .LOAD_GUESS(lg1), .CLR_REGS(clr1),
    .HITS(hits1), .TRIES(tries1), .WIN(win1), .LOSE(lose1), .BUSY(busy1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register datapath model, controlled by the main instance's strobes.
  always @(posedge CLK) begin
    if (clr8) begin
      sec_q <= 4'd0;
      gs_q  <= 4'd0;
    end else begin
      if (ls8) sec_q <= din;
      if (lg8) gs_q  <= din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe pulse counting and mutual exclusion of the state-decoded outputs.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (clr8) n_clr++;
      if (ls8)  n_ls++;
      if (lg8)  n_lg++;
      check("onehot_strobes", {31'd0, $onehot0({ls8, lg8, clr8, win8, lose8})}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    din   = d;
    ENTER = 1'b1;
    tick();
    ENTER = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("reset_outputs", {19'd0, all8}, 32'd0);
  endtask

  // From IDLE/WIN/LOSE: start, clear, load the secret, end in WAIT_GUESS.
  task automatic start_game(input logic [3:0] s);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("clear_strobe", {31'd0, clr8}, 32'd1);
    check("clear_busy", {31'd0, busy8}, 32'd1);
    tick();
    check("setsec_noclr", {31'd0, clr8}, 32'd0);
    press(s);
    check("load_secret", {31'd0, ls8}, 32'd1);
    tick();
    check("load_secret_end", {31'd0, ls8}, 32'd0);
  endtask

  // Enter a guess; the score is compared three edges after the press.
  task automatic guess(input logic [3:0] g, input logic [2:0] h, input logic [3:0] t,
                       input logic w, input logic l);
    exp_t e;
    e.hits  = h;
    e.tries = t;
    e.win   = w;
    e.lose  = l;
    e.busy  = ~(w | l);
    sb.push_back(e);
    press(g);
    tick();
    tick();
    e = sb.pop_front();
    check("hits", {29'd0, hits8}, {29'd0, e.hits});
    check("tries", {28'd0, tries8}, {28'd0, e.tries});
    check("win", {31'd0, win8}, {31'd0, e.win});
    check("lose", {31'd0, lose8}, {31'd0, e.lose});
    check("busy", {31'd0, busy8}, {31'd0, e.busy});
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    ENTER = 1'b1;
    din   = 4'd0;

    // 1: reset with ENTER high, then ENTER held in IDLE
    tick();
    tick();
    RESET = 1'b0;
    check("reset_outputs", {19'd0, all8}, 32'd0);
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outputs", {19'd0, all8}, 32'd0);
    end
    ENTER = 1'b0;
    tick();
    check("idle_no_loads", n_ls + n_lg, 32'd0);

    // 2: win on the first guess
    start_game(4'b1010);
    guess(4'b1010, 3'd4, 4'd1, 1'b1, 1'b0);
    check("t2_clr_cnt", n_clr, 32'd1);
    check("t2_ls_cnt", n_ls, 32'd1);
    check("t2_lg_cnt", n_lg, 32'd1);

    // 3: partial scoring
    start_game(4'b1100);
    guess(4'b1111, 3'd2, 4'd1, 1'b0, 1'b0);
    guess(4'b0011, 3'd0, 4'd2, 1'b0, 1'b0);
    guess(4'b1101, 3'd3, 4'd3, 1'b0, 1'b0);

    // 4: lose at the limit; a 9th enter is ignored
    do_reset();
    start_game(4'b0001);
    base_lg = n_lg;
    for (int i = 1; i <= 8; i++) begin
      guess(4'b1110, 3'd0, 4'(i), 1'b0, (i == 8));
    end
    guess(4'b0001, 3'd0, 4'd8, 1'b0, 1'b1);
    check("t4_lg_cnt", n_lg - base_lg, 32'd8);

    // 5: win on the last try (MAX_TRIES=2), immediate loss (MAX_TRIES=1)
    start_game(4'b0110);
    guess(4'b0111, 3'd3, 4'd1, 1'b0, 1'b0);
    check("m2_busy", {31'd0, busy2}, 32'd1);
    check("m2_tries", {28'd0, tries2}, 32'd1);
    check("m1_lose", {31'd0, lose1}, 32'd1);
    check("m1_tries", {28'd0, tries1}, 32'd1);
    check("m1_hits", {29'd0, hits1}, 32'd3);
    guess(4'b0110, 3'd4, 4'd2, 1'b1, 1'b0);
    check("m2_win", {31'd0, win2}, 32'd1);
    check("m2_lose", {31'd0, lose2}, 32'd0);
    check("m2_tries_final", {28'd0, tries2}, 32'd2);
    check("m2_hits", {29'd0, hits2}, 32'd4);
    check("m1_still_lose", {31'd0, lose1}, 32'd1);
    check("m1_tries_hold", {28'd0, tries1}, 32'd1);

    // 6: reset mid-game at TRIES=3, then START held for 4 cycles
    start_game(4'b0101);
    guess(4'b1010, 3'd0, 4'd1, 1'b0, 1'b0);
    guess(4'b1010, 3'd0, 4'd2, 1'b0, 1'b0);
    guess(4'b1010, 3'd0, 4'd3, 1'b0, 1'b0);
    do_reset();
    base_clr = n_clr;
    base_ls  = n_ls;
    START = 1'b1;
    tick();
    check("t6_clear", {31'd0, clr8}, 32'd1);
    ENTER = 1'b1;  // rises during CLEAR: must be dropped
    tick();
    check("t6_setsec_busy", {31'd0, busy8}, 32'd1);
    check("t6_setsec_noload", {31'd0, ls8}, 32'd0);
    tick();
    check("t6_hold_noload", {31'd0, ls8}, 32'd0);
    tick();
    check("t6_hold_noclr", {31'd0, clr8}, 32'd0);
    check("t6_tries", {28'd0, tries8}, 32'd0);
    START = 1'b0;
    ENTER = 1'b0;
    tick();
    check("t6_clr_cnt", n_clr - base_clr, 32'd1);
    check("t6_ls_cnt", n_ls - base_ls, 32'd0);
    press(4'b0011);
    check("t6_secret_accepts", {31'd0, ls8}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mastermind_game_ctrl.md
Name: mastermind_game_ctrl

Overview:
- Game sequencer for the Mastermind datapath.
- Drives the LOAD and clear controls of two 4-bit registers, the secret register and the guess register, from player START/ENTER inputs.
- Scores each guess by counting exact position matches between the two register outputs, and tracks the attempt count.
- Declares WIN or LOSE; sits between the player input debouncers and the register datapath.

Parameters:
- MAX_TRIES, 8, guesses allowed per game; legal range 1..(2^TRY_W)-1.
- TRY_W, 4, width of the attempt counter and of the TRIES output.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous active-high reset.
- START  input  1  level; starts a new game, honoured only in IDLE, WIN and LOSE.
- ENTER  input  1  level from debouncer; each 0->1 transition is one "enter" event.
- SECRET_Q  input  4  secret register outputs s3..s0.
- GUESS_Q  input  4  guess register outputs s3..s0.
- LOAD_SECRET  output  1  LOAD strobe to the secret register.
- LOAD_GUESS  output  1  LOAD strobe to the guess register.
- CLR_REGS  output  1  clear strobe to both registers' RESET.
- HITS  output  3  exact matches of the last scored guess, 0..4.
- TRIES  output  TRY_W  guesses scored in the current game.
- WIN  output  1  game won.
- LOSE  output  1  game lost.
- BUSY  output  1  game in progress.

Behaviour:
- All state changes occur on the rising edge of CLK. RESET is sampled on the clock edge and has priority over everything else.
- Reset values:
  - State = IDLE.
  - HITS = 0 and TRIES = 0.
  - LOAD_SECRET, LOAD_GUESS, CLR_REGS, WIN, LOSE and BUSY = 0.
  - The ENTER delay flop = 1, so ENTER held high through reset produces no event.
- Enter event: enter_rise = ENTER & ~ENTER_d, where ENTER_d is ENTER registered. An event is consumed only in SET_SECRET or WAIT_GUESS; in all other states it is dropped and never queued.
- State transitions:
  - IDLE: START=1 -> CLEAR.
  - CLEAR: CLR_REGS=1 for exactly one cycle; HITS<=0, TRIES<=0 -> SET_SECRET.
  - SET_SECRET: enter_rise -> LD_SEC; otherwise stay.
  - LD_SEC: LOAD_SECRET=1 for one cycle -> WAIT_GUESS.
  - WAIT_GUESS: enter_rise -> LD_GUESS; otherwise stay. START is ignored.
  - LD_GUESS: LOAD_GUESS=1 for one cycle -> COMPARE. The register captures at the end of this cycle, so GUESS_Q is valid in COMPARE.
  - COMPARE (one cycle):
    - HITS <= popcount(~(SECRET_Q ^ GUESS_Q)), computed 3 bits wide.
    - TRIES <= TRIES+1.
    - Next state: if the match count = 4 -> WIN; else if TRIES+1 = MAX_TRIES -> LOSE; else -> WAIT_GUESS.
    - WIN has priority over LOSE on the final try.
  - WIN: WIN=1; HITS and TRIES hold; START=1 -> CLEAR.
  - LOSE: LOSE=1; HITS and TRIES hold; START=1 -> CLEAR.
- Moore outputs decoded from state:
  - LOAD_SECRET, LOAD_GUESS, CLR_REGS, WIN, LOSE are each high only in their own state and mutually exclusive.
  - BUSY=1 in every state except IDLE, WIN and LOSE.
- HITS and TRIES are registered and change only in CLEAR and COMPARE.
- Latency: enter_rise in WAIT_GUESS to HITS/TRIES update = 3 clock edges (WAIT_GUESS -> LD_GUESS -> COMPARE -> next).
- TRIES never exceeds MAX_TRIES; no wrap is possible within the legal parameter range.
- MAX_TRIES=1: the first non-matching guess goes straight to LOSE.
- START held high in WIN/LOSE: exactly one CLEAR is issued, then the block proceeds to SET_SECRET. A START still high there is ignored.
- RESET mid-game (any state): next cycle is IDLE with all outputs 0. The registers are not cleared until the next CLEAR.
- ENTER held high across several cycles = one event only.

Test Plan:
1. Reset then idle:
   - Stimulus: RESET=1 for 2 cycles with ENTER=1, then release; hold ENTER=1 for 5 cycles.
   - Response: state stays IDLE; all outputs 0; no LOAD strobes.
2. Win on the first guess:
   - Stimulus: START pulse; ENTER pulse (secret 4'b1010 presented); ENTER pulse with guess 4'b1010.
   - Response: CLR_REGS 1 cycle, LOAD_SECRET 1 cycle, LOAD_GUESS 1 cycle. After COMPARE: HITS=4, TRIES=1, WIN=1, BUSY=0.
3. Partial scoring:
   - Stimulus: secret 4'b1100; guesses 4'b1111, then 4'b0011, then 4'b1101.
   - Response: HITS=2, TRIES=1; then HITS=0, TRIES=2; then HITS=3, TRIES=3; WIN=0, LOSE=0, BUSY=1 throughout.
4. Lose at limit:
   - Stimulus: MAX_TRIES=8; secret 4'b0001; 8 guesses of 4'b1110.
   - Response: HITS=0 each time; after the 8th guess TRIES=8, LOSE=1. A 9th ENTER is ignored and TRIES stays 8.
5. Win on the last try:
   - Stimulus: MAX_TRIES=2; first guess wrong, second guess matches.
   - Response: WIN=1, LOSE=0, TRIES=2.
6. Reset mid-game and restart:
   - Stimulus: RESET asserted in WAIT_GUESS at TRIES=3; then START held 4 cycles.
   - Response: IDLE with TRIES=0 next cycle; exactly one CLR_REGS pulse; then SET_SECRET with BUSY=1. Extra ENTER events during CLEAR are dropped.
